// File: rtl/coherent_mem_arbiter_pkg.sv
// coherent_mem_arbiter_pkg: shared types and helpers for the multicore memory arbiter
package coherent_mem_arbiter_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [1:0] {RD_I, RD_D, WR_D} req_kind_t;
    typedef enum logic [1:0] {IDLE, SERVE, INV} arb_state_t;
    localparam int CPUS_DEF = 2;
    function automatic int id_w(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/coherent_mem_arbiter_if.sv
// coherent_mem_arbiter_if: cache-control bundle between the cache layer, the arbiter and the RAM
interface coherent_mem_arbiter_if import coherent_mem_arbiter_pkg::*; #(
    parameter int CPUS = CPUS_DEF
);
    logic [CPUS-1:0]  iREN, iwait, dREN, dWEN, dwait, ccinv;
    word_t [CPUS-1:0] iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
    logic             ramREN, ramWEN;
    word_t            ramaddr, ramstore, ramload;
    ramstate_t        ramstate;
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        output iwait, iload, dwait, dload, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore
    );
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        input  iwait, iload, dwait, dload, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/coherent_mem_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, nearest requester at or after ptr wins
module rr_arbiter import coherent_mem_arbiter_pkg::*; #(
    parameter int N = 2,
    localparam int W = id_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);
    int best, off;
    // rank each requester by its distance from ptr and keep the closest
    always_comb begin
        gnt = '0;
        idx = '0;
        best = N;
        off = 0;
        for (int k = 0; k < N; k++) begin
            off = (k + N - int'(ptr)) % N;
            if (req[k] && off < best) begin
                best = off;
                gnt = '0;
                gnt[k] = 1'b1;
                idx = W'(k);
            end
        end
    end
endmodule

// File: rtl/coherent_mem_arbiter.sv
// coherent_mem_arbiter: shares one RAM port among CPUS icache/dcache pairs and broadcasts write invalidates
module coherent_mem_arbiter import coherent_mem_arbiter_pkg::*; #(
    parameter int CPUS = CPUS_DEF
) (
    input logic CLK,
    input logic nRST,
    coherent_mem_arbiter_if.slave bus
);
    localparam int W = id_w(CPUS);
    localparam logic [W-1:0] LAST = W'(CPUS - 1);

    arb_state_t      state;
    req_kind_t       gkind, pkind;
    logic [W-1:0]    rr, gcpu, pick;
    word_t           gaddr, gdata;
    logic [CPUS-1:0] req, gnt;
    logic            live, done, inv;

    assign req = bus.iREN | bus.dREN | bus.dWEN;
    assign bus.ramaddr = gaddr;
    assign bus.ramstore = gdata;
    assign bus.iload = {CPUS{bus.ramload}};
    assign bus.dload = {CPUS{bus.ramload}};

    rr_arbiter #(.N(CPUS)) u_rr (.req(req), .ptr(rr), .gnt(gnt), .idx(pick));

    // within the picked cpu a write outranks a data read, which outranks an instruction fetch
    always_comb pkind = bus.dWEN[pick] ? WR_D : bus.dREN[pick] ? RD_D : RD_I;

    // live: the granted enable is still up; done: RAM completes for a live grant this cycle
    always_comb begin
        live = gkind == WR_D ? bus.dWEN[gcpu] : gkind == RD_D ? bus.dREN[gcpu] : bus.iREN[gcpu];
        done = state == SERVE && live && bus.ramstate == ACCESS;
        inv = done && gkind == WR_D;
    end

    // only the granted cache sees its wait drop, and only in the completing cycle
    always_comb begin
        bus.iwait = '1;
        bus.dwait = '1;
        if (done && gkind == RD_I) bus.iwait[gcpu] = 1'b0;
        if (done && gkind != RD_I) bus.dwait[gcpu] = 1'b0;
    end

    // arbitration, RAM handshake and the one-cycle invalidate broadcast
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            rr <= '0;
            gcpu <= '0;
            gkind <= RD_I;
            gaddr <= '0;
            gdata <= '0;
            bus.ramREN <= 1'b0;
            bus.ramWEN <= 1'b0;
            bus.ccinv <= '0;
            bus.ccsnoopaddr <= '0;
        end else begin
            case (state)
                IDLE: if (|gnt) begin
                    state <= SERVE;
                    gcpu <= pick;
                    gkind <= pkind;
                    gaddr <= pkind == RD_I ? bus.iaddr[pick] : bus.daddr[pick];
                    gdata <= bus.dstore[pick];
                    bus.ramREN <= pkind != WR_D;
                    bus.ramWEN <= pkind == WR_D;
                end
                SERVE: if (!live || bus.ramstate == ERROR || done) begin
                    state <= inv ? INV : IDLE;
                    bus.ramREN <= 1'b0;
                    bus.ramWEN <= 1'b0;
                    if (done) rr <= gcpu == LAST ? '0 : gcpu + 1'b1;
                    for (int k = 0; k < CPUS; k++) begin
                        bus.ccinv[k] <= inv && k != int'(gcpu);
                        bus.ccsnoopaddr[k] <= inv && k != int'(gcpu) ? gaddr : '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    bus.ccinv <= '0;
                    bus.ccsnoopaddr <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_coherent_mem_arbiter.sv
// tb_coherent_mem_arbiter: scoreboard bench with a latency-LAT RAM model and a reference memory
module tb_coherent_mem_arbiter;
    import coherent_mem_arbiter_pkg::*;
    localparam int CPUS = 2;
    localparam int LAT = 10;
    localparam int NC = 2 * CPUS;   // cache c: even = icache of cpu c/2, odd = dcache of cpu c/2

    typedef struct packed { logic wr; word_t a; word_t d; } exp_t;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    coherent_mem_arbiter_if #(.CPUS(CPUS)) bus ();
    coherent_mem_arbiter #(.CPUS(CPUS)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
    always #5 CLK = ~CLK;

    int checks = 0;
    int passed = 0;
    exp_t expq[NC][$];
    word_t ref_mem [4096];
    logic [31:0] mem [4096];
    logic act [NC];
    int log_q[$];
    int cnt = 0;
    logic err_inj = 1'b0;
    logic inv_pend = 1'b0;
    logic [CPUS-1:0] inv_mask = '0;
    word_t inv_addr = '0;

    function automatic void chk(string name, logic [95:0] got, logic [95:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endfunction

    function automatic logic wait_of(int c);
        return c % 2 == 1 ? bus.dwait[c / 2] : bus.iwait[c / 2];
    endfunction

    function automatic word_t load_of(int c);
        return c % 2 == 1 ? bus.dload[c / 2] : bus.iload[c / 2];
    endfunction

    function automatic logic busy();
        logic b = 1'b0;
        for (int c = 0; c < NC; c++) b = b | act[c];
        return b;
    endfunction

    // RAM model: memory preloaded with word value = address, completes after LAT cycles
    initial for (int i = 0; i < 4096; i++) mem[i] = 32'(i);
    always_comb bus.ramstate = err_inj ? ERROR : !(bus.ramREN || bus.ramWEN) ? FREE :
                               cnt == LAT - 1 ? ACCESS : BUSY;
    assign bus.ramload = mem[bus.ramaddr[11:0]];
    always @(posedge CLK) begin
        cnt <= bus.ramstate == BUSY ? cnt + 1 : 0;
        if (bus.ramstate == ACCESS && bus.ramWEN) mem[bus.ramaddr[11:0]] <= bus.ramstore;
    end

    // monitor: pops the expected response of whichever cache sees its wait drop
    always @(negedge CLK) begin
        if (inv_pend || bus.ccinv != '0) begin
            chk("ccinv", bus.ccinv, inv_pend ? inv_mask : '0);
            for (int k = 0; k < CPUS; k++)
                if (inv_pend && inv_mask[k]) chk("ccsnoopaddr", bus.ccsnoopaddr[k], inv_addr);
        end
        inv_pend <= 1'b0;
        if ($countones(~bus.iwait) + $countones(~bus.dwait) > 0)
            chk("waits_low", $countones(~bus.iwait) + $countones(~bus.dwait), 1);
        for (int c = 0; c < NC; c++) begin
            if (!wait_of(c)) begin
                if (expq[c].size() == 0) chk($sformatf("spurious_wait[%0d]", c), 1, 0);
                else begin
                    if (expq[c][0].wr) begin
                        chk("write", {bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore},
                            {2'b10, expq[c][0].a, expq[c][0].d});
                        inv_pend <= 1'b1;
                        inv_mask <= {CPUS{1'b1}} ^ (CPUS'(1) << (c / 2));
                        inv_addr <= expq[c][0].a;
                    end else
                        chk("read", {bus.ramREN, bus.ramWEN, bus.ramaddr, load_of(c)},
                            {2'b10, expq[c][0].a, expq[c][0].d});
                    void'(expq[c].pop_front());
                end
            end
        end
    end

    task automatic issue(int c, bit wr, word_t a, word_t d, bit track = 1'b1);
        int n;
        exp_t e;
        n = c / 2;
        e.wr = wr && c % 2 == 1;
        e.a = a;
        e.d = e.wr ? d : ref_mem[a[11:0]];
        if (e.wr) ref_mem[a[11:0]] = d;
        if (c % 2 == 1) begin
            bus.daddr[n] = a;
            bus.dstore[n] = d;
            bus.dWEN[n] = e.wr;
            bus.dREN[n] = !e.wr || $urandom_range(0, 1) == 1;
        end else begin
            bus.iaddr[n] = a;
            bus.iREN[n] = 1'b1;
        end
        if (track) expq[c].push_back(e);
        act[c] = 1'b1;
    endtask

    task automatic drop_req(int c);
        if (c % 2 == 1) begin
            bus.dREN[c / 2] = 1'b0;
            bus.dWEN[c / 2] = 1'b0;
        end else bus.iREN[c / 2] = 1'b0;
        act[c] = 1'b0;
    endtask

    task automatic rand_issue(int c);
        if (c % 2 == 0) issue(c, 1'b0, word_t'($urandom_range(0, 255) * 4), '0);
        else issue(c, $urandom_range(0, 1) == 1,
                   word_t'(32'h800 + (c / 2) * 32'h200 + $urandom_range(0, 127) * 4), $urandom);
    endtask

    // one cycle: note completions at the falling edge, withdraw those requests after the next rise
    task automatic step();
        bit fin [NC];
        @(negedge CLK);
        for (int c = 0; c < NC; c++) begin
            fin[c] = act[c] && !wait_of(c);
            if (fin[c]) log_q.push_back(c);
        end
        @(posedge CLK);
        #1;
        for (int c = 0; c < NC; c++) if (fin[c]) drop_req(c);
    endtask

    task automatic drain(int limit, string name);
        int k = 0;
        while (busy() && k < limit) begin
            step();
            k++;
        end
        chk(name, busy(), 0);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 4096; i++) ref_mem[i] = word_t'(i);
        for (int c = 0; c < NC; c++) act[c] = 1'b0;
        bus.iREN = '0;
        bus.dREN = '0;
        bus.dWEN = '0;
        bus.iaddr = '0;
        bus.daddr = '0;
        bus.dstore = '0;
        #12;
        chk("rst_ram_en", {bus.ramREN, bus.ramWEN}, 0);
        chk("rst_ramaddr", bus.ramaddr, 0);
        chk("rst_waits", {bus.iwait, bus.dwait}, {2 * CPUS{1'b1}});
        chk("rst_ccinv", bus.ccinv, 0);
        @(posedge CLK);
        #1 nRST = 1'b1;
        // single data read: RAM enabled the next cycle, done LAT cycles later
        issue(1, 1'b0, 32'h04, '0);
        step();
        chk("t1_ram_req", {bus.ramREN, bus.ramWEN, bus.ramaddr}, {2'b10, 32'h04});
        k = 1;
        while (act[1] && k < 100) begin
            step();
            k++;
        end
        chk("t1_latency", k, LAT + 1);
        // same-cpu icache and dcache: dcache first
        log_q.delete();
        issue(0, 1'b0, 32'h00, '0);
        issue(1, 1'b0, 32'h08, '0);
        drain(200, "t2_drain");
        chk("t2_order", {log_q.size() > 1 ? log_q[0] : -1, log_q.size() > 1 ? log_q[1] : -1}, {32'd1, 32'd0});
        // two dcaches held high: grants alternate, cpu1 first since cpu0 finished last
        log_q.delete();
        issue(1, 1'b0, 32'h80, '0);
        issue(3, 1'b0, 32'hC0, '0);
        for (int t = 0; t < 300 && log_q.size() < 6; t++) begin
            step();
            if (log_q.size() < 6) begin
                if (!act[1]) issue(1, 1'b0, 32'h80, '0);
                if (!act[3]) issue(3, 1'b0, 32'hC0, '0);
            end
        end
        drain(100, "t3_drain");
        chk("t3_count", log_q.size() >= 6, 1);
        chk("t3_first", log_q.size() > 0 ? log_q[0] : -1, 3);
        for (int i = 1; i < 6 && i < log_q.size(); i++) chk("t3_alternate", log_q[i] != log_q[i - 1], 1);
        // write with invalidate, then read back from the other cpu
        issue(3, 1'b1, 32'h40, 32'hDEADBEEF);
        drain(100, "t4_write");
        issue(1, 1'b0, 32'h40, '0);
        drain(100, "t4_read");
        // reset in the middle of a grant
        log_q.delete();
        issue(1, 1'b0, 32'h10, '0, 1'b0);
        repeat (3) step();
        chk("t5_serving", bus.ramREN, 1);
        #2 nRST = 1'b0;
        #1;
        chk("t5_rst_en", {bus.ramREN, bus.ramWEN}, 0);
        chk("t5_rst_waits", {bus.iwait, bus.dwait}, {2 * CPUS{1'b1}});
        chk("t5_rst_ccinv", bus.ccinv, 0);
        drop_req(1);
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        step();
        chk("t5_idle", {bus.ramREN, bus.ramWEN}, 0);
        issue(1, 1'b0, 32'h14, '0);
        issue(3, 1'b0, 32'h18, '0);
        drain(200, "t5_drain");
        chk("t5_rr_reset", log_q.size() > 0 ? log_q[0] : -1, 1);
        // one ERROR cycle: no completion, request re-granted and served in full
        issue(1, 1'b0, 32'h20, '0);
        repeat (4) step();
        err_inj = 1'b1;
        @(negedge CLK);
        chk("t6_no_drop", bus.dwait[0], 1);
        @(posedge CLK);
        #1 err_inj = 1'b0;
        k = 0;
        while (act[1] && k < 100) begin
            step();
            k++;
        end
        chk("t6_latency", k, LAT + 1);
        // random traffic from every cache
        for (int t = 0; t < 400; t++) begin
            step();
            for (int c = 0; c < NC; c++) if (!act[c] && $urandom_range(0, 2) == 0) rand_issue(c);
        end
        drain(600, "rand_drain");
        for (int c = 0; c < NC; c++) chk("queue_empty", expq[c].size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
